corescore_uart_tx_stream: RTL and testbench
===========================================

Name: corescore_uart_tx_stream

Overview:
- Serial UART transmitter that consumes the corescorecore byte stream (tdata/tlast/tvalid/tready) and drives an 8N1 TX pin.
- Used on boards that have a physical UART pin instead of an on-chip JTAG UART.
- A small FIFO decouples stream bursts from the baud rate. The tlast marker is carried through so that end-of-message completion is visible.

Parameters:
- CLK_FREQ_HZ, 16000000, input clock frequency in Hz.
- BAUD_RATE, 57600, serial bit rate.
- FIFO_AW, 4, log2 of FIFO depth (depth 16 entries, each 9 bits: tlast plus data).

Ports:
- i_clk  in  1  system clock, all logic on rising edge.
- i_rst  in  1  synchronous active-high reset.
- i_tdata  in  8  stream byte.
- i_tlast  in  1  last byte of a message.
- i_tvalid  in  1  stream byte valid.
- o_tready  out  1  registered; high when the FIFO can accept a byte.
- o_uart_tx  out  1  serial line, idle high, registered.
- o_busy  out  1  high when the FIFO is non-empty or the FSM is not IDLE.
- o_msg_done  out  1  one-cycle pulse at the end of the stop bit of a byte that had tlast=1.

Behaviour:
- DIV = (CLK_FREQ_HZ + BAUD_RATE/2) / BAUD_RATE, rounded to nearest; 16 MHz/57600 gives 278. Elaboration error if DIV < 2.
- Each serial bit is held for exactly DIV clocks. Baud counter counts 0..DIV-1 and restarts at every bit boundary.
- Reset values: o_uart_tx=1, o_tready=0, o_busy=0, o_msg_done=0. FIFO is empty and the FSM is in IDLE.
- o_tready rises on the first cycle after i_rst deasserts.
- Accept rule: a byte is written to the FIFO when i_tvalid & o_tready.
  - o_tready next = (occupancy after this cycle's push/pop) < depth.
  - A push and a pop in the same cycle leave occupancy unchanged.
  - No push occurs when full, because o_tready=0.
- Frame format: start bit (0), data bits 0..7 LSB first, optional parity, one stop bit (1).
- FSM states IDLE, START, DATA, PARITY, STOP:
  - IDLE: line is 1. If the FIFO is non-empty, pop the head into the shift register and go to START.
  - START: line is 0 for DIV cycles, then go to DATA with bit index 0.
  - DATA: line is shift[0] for DIV cycles, then shift right. After bit 7 go to PARITY if enabled, otherwise STOP.
  - PARITY: line is the parity bit for DIV cycles, then go to STOP.
  - STOP: line is 1 for DIV cycles.
    - At the final cycle, pulse o_msg_done if the saved tlast is 1.
    - If the FIFO is non-empty, pop and go directly to START with no idle gap; otherwise go to IDLE.
- Latency: a byte accepted at edge N into an empty, idle block drives the start bit on o_uart_tx from edge N+2.
- Frame length: 10*DIV cycles, or 11*DIV with parity.
- i_rst mid-frame forces the line high on the next edge, discards the frame in progress and flushes the FIFO.
- i_tvalid deasserted mid-message has no effect on a frame already in flight.

Optional Feature:
- Macro: CORESCORE_UART_TX_PARITY_EN.
- Defined: the PARITY state is inserted and the parity bit is even parity, i.e. the XOR of the 8 data bits (8E1).
- Undefined: the PARITY state and its logic are absent (8N1); STOP follows bit 7 directly.
- Ports are identical in both builds.

Decomposition:
- Package corescore_uart_pkg holds:
  - typedef tx_state_e {IDLE, START, DATA, PARITY, STOP}.
  - function calc_div(clk_hz, baud).
  - localparams for data width 8 and stop bits 1.
- Sub-module corescore_sync_fifo (width 9, parameter AW):
  - ports: push, pop, wdata, rdata, empty, full, count.
  - first-word-fall-through read.

Test Plan:
- CLK_FREQ_HZ=4, BAUD_RATE=1 (DIV=4), send 0x55 tlast=1 when idle.
  - o_uart_tx reads 0,1,0,1,0,1,0,1,0,1, each held 4 cycles; start bit at edge N+2.
  - o_msg_done pulses once at cycle 40 of the frame.
- Burst of 20 bytes 0x00..0x13, tvalid held high, DIV=4.
  - o_tready drops after 16 in FIFO; all 20 bytes arrive in order.
  - Stop to start is back-to-back, 800 cycles total.
  - o_msg_done fires only after 0x13, which had tlast=1.
- Assert i_rst during bit 3 of 0xA5.
  - Next edge: o_uart_tx=1, o_busy=0, o_tready=0.
  - After release, a fresh 0x3C is transmitted correctly.
- Toggle i_tvalid every other cycle with 4 bytes: each byte is accepted exactly once and none is duplicated.
- With CORESCORE_UART_TX_PARITY_EN, send 0x07: parity bit 1, frame 44 cycles. Send 0x03: parity bit 0.
- Default parameters: DIV=278, and the start bit width measures 278 clocks.

Source files
------------

// File: rtl/corescore_uart_pkg.sv
// corescore_uart_pkg
// Shared types and helpers for the corescore UART transmitter.
//   tx_state_e : transmitter FSM states (PARITY is only reachable when the
//                CORESCORE_UART_TX_PARITY_EN build macro is defined)
//   calc_div   : clocks per serial bit, rounded to nearest
//   DATA_BITS, STOP_BITS, FIFO_W : frame and FIFO entry geometry
package corescore_uart_pkg;

  localparam int DATA_BITS = 8;
  localparam int STOP_BITS = 1;
  // One FIFO entry carries tlast above the data byte.
  localparam int FIFO_W    = DATA_BITS + 1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_e;

  // Nearest-integer division: 16 MHz / 57600 baud -> 278.
  function automatic int calc_div(input int clk_hz, input int baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/corescore_sync_fifo.sv
// corescore_sync_fifo
// Single-clock FIFO with first-word-fall-through read: o_rdata always shows
// the head entry while o_empty is low, and i_pop retires it.
//   i_clk, i_rst      : clock, synchronous active-high reset (empties FIFO)
//   i_push, i_wdata   : write an entry (ignored while full)
//   i_pop             : retire the head entry (ignored while empty)
//   o_rdata           : head entry
//   o_empty, o_full   : occupancy flags
//   o_count           : occupancy, 0 .. 2**AW
module corescore_sync_fifo
  import corescore_uart_pkg::*;
#(
  parameter int W  = FIFO_W,
  parameter int AW = 4
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic [W-1:0]  i_wdata,
  output logic [W-1:0]  o_rdata,
  output logic          o_empty,
  output logic          o_full,
  output logic [AW:0]   o_count
);

  localparam int DEPTH = 1 << AW;

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_do_push;
  logic          w_do_pop;

  assign w_do_push = i_push & ~o_full;
  assign w_do_pop  = i_pop & ~o_empty;

  // Storage carries no reset; validity is tracked by the pointers.
  always_ff @(posedge i_clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_rdata = r_mem[r_rd_ptr];
  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_count = r_count;

endmodule

// File: rtl/corescore_uart_tx_stream.sv
// corescore_uart_tx_stream
// UART transmitter fed by the corescore byte stream. Bytes are buffered in a
// small FIFO and sent as 8N1 frames (8E1 when CORESCORE_UART_TX_PARITY_EN is
// defined). Back-to-back frames have no idle gap between stop and start.
//   i_clk, i_rst     : clock, synchronous active-high reset
//   i_tdata, i_tlast : stream byte and end-of-message marker
//   i_tvalid         : stream byte valid
//   o_tready         : registered, high while the FIFO can take a byte
//   o_uart_tx        : registered serial line, idle high
//   o_busy           : FIFO non-empty or a frame in progress
//   o_msg_done       : one-cycle pulse at the end of the stop bit of a tlast byte
// Build macro: CORESCORE_UART_TX_PARITY_EN adds an even parity bit.
//
// Handshake: a byte transfers on a rising edge where i_tvalid and o_tready
// are both high; i_tdata/i_tlast are sampled only on that edge, and the
// source may drop i_tvalid at any time without affecting frames in flight.
module corescore_uart_tx_stream
  import corescore_uart_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 16000000,
  parameter int BAUD_RATE   = 57600,
  parameter int FIFO_AW     = 4
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [7:0] i_tdata,
  input  logic       i_tlast,
  input  logic       i_tvalid,
  output logic       o_tready,
  output logic       o_uart_tx,
  output logic       o_busy,
  output logic       o_msg_done
);

  localparam int DIV   = calc_div(CLK_FREQ_HZ, BAUD_RATE);
  localparam int CW    = (DIV >= 2) ? $clog2(DIV) : 1;
  localparam int DEPTH = 1 << FIFO_AW;

  if (DIV < 2) begin : g_div_check
    $error("corescore_uart_tx_stream: clocks per bit must be at least 2");
  end

  // FIFO interface
  logic              w_push;
  logic              w_pop;
  logic              w_empty;
  logic              w_full;
  logic [FIFO_W-1:0] w_rdata;
  logic [FIFO_AW:0]  w_count;
  logic [FIFO_AW:0]  w_count_nxt;

  // FSM and datapath
  tx_state_e         r_state;
  tx_state_e         w_state_nxt;
  logic [CW-1:0]     r_cnt;
  logic [2:0]        r_bit;
  logic [7:0]        r_shift;
  logic              r_last;
  logic              r_tx;
  logic              r_msg_done;
  logic              r_tready;
  logic              w_bit_end;
  logic              w_line;
  logic              w_done;

  assign w_push = i_tvalid & r_tready & ~w_full;

  corescore_sync_fifo #(
    .W  (FIFO_W),
    .AW (FIFO_AW)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_wdata ({i_tlast, i_tdata}),
    .o_rdata (w_rdata),
    .o_empty (w_empty),
    .o_full  (w_full),
    .o_count (w_count)
  );

  // Occupancy after this edge decides whether the next cycle can accept.
  assign w_count_nxt = w_count + {{FIFO_AW{1'b0}}, w_push} - {{FIFO_AW{1'b0}}, w_pop};

  assign w_bit_end = (r_cnt == CW'(DIV - 1));

`ifdef CORESCORE_UART_TX_PARITY_EN
  logic r_par;

  // Parity is captured at load time because the shift register is empty
  // by the time the parity bit goes out.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_par <= 1'b0;
    end else if (w_pop) begin
      r_par <= ^w_rdata[7:0];
    end
  end
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_line      = 1'b1;
    w_done      = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = START;
        end
      end
      START: begin
        w_line = 1'b0;
        if (w_bit_end) begin
          w_state_nxt = DATA;
        end
      end
      DATA: begin
        w_line = r_shift[0];
        if (w_bit_end && (r_bit == 3'(DATA_BITS - 1))) begin
`ifdef CORESCORE_UART_TX_PARITY_EN
          w_state_nxt = PARITY;
`else
          w_state_nxt = STOP;
`endif
        end
      end
`ifdef CORESCORE_UART_TX_PARITY_EN
      PARITY: begin
        w_line = r_par;
        if (w_bit_end) begin
          w_state_nxt = STOP;
        end
      end
`endif
      STOP: begin
        w_line = 1'b1;
        if (w_bit_end) begin
          w_done = r_last;
          // Chain straight into the next frame when data is waiting.
          if (!w_empty) begin
            w_pop       = 1'b1;
            w_state_nxt = START;
          end else begin
            w_state_nxt = IDLE;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // The line register presents each state's level one cycle later, which
  // places the start bit two edges after the accepting edge.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_bit      <= '0;
      r_shift    <= '0;
      r_last     <= 1'b0;
      r_tx       <= 1'b1;
      r_msg_done <= 1'b0;
      r_tready   <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_tx       <= w_line;
      r_msg_done <= w_done;
      r_tready   <= (w_count_nxt < (FIFO_AW+1)'(DEPTH));
      if ((r_state == IDLE) || w_bit_end) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
      if (w_pop) begin
        r_shift <= w_rdata[7:0];
        r_last  <= w_rdata[8];
        r_bit   <= '0;
      end else if ((r_state == DATA) && w_bit_end) begin
        r_shift <= {1'b0, r_shift[7:1]};
        r_bit   <= r_bit + 3'd1;
      end
    end
  end

  assign o_tready   = r_tready;
  assign o_uart_tx  = r_tx;
  assign o_busy     = (r_state != IDLE) | ~w_empty;
  assign o_msg_done = r_msg_done;

endmodule

// File: tb/tb_corescore_uart_tx_stream.sv
// tb_corescore_uart_tx_stream
// Bench for corescore_uart_tx_stream with DIV=4 (main instance) and default
// parameters (second instance, start bit width only). A frame-level model
// predicts every output each cycle; a mid-bit line decoder scores received
// bytes against the accepted-byte queue.
module tb_corescore_uart_tx_stream;

`ifdef CORESCORE_UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int DIV4 = 4;
  localparam int FL   = NB * DIV4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUT (DIV = 4) ----------------
  logic [7:0] i_tdata  = 8'h00;
  logic       i_tlast  = 1'b0;
  logic       i_tvalid = 1'b0;
  logic       o_tready;
  logic       o_uart_tx;
  logic       o_busy;
  logic       o_msg_done;

  corescore_uart_tx_stream #(
    .CLK_FREQ_HZ (4),
    .BAUD_RATE   (1),
    .FIFO_AW     (4)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_tdata    (i_tdata),
    .i_tlast    (i_tlast),
    .i_tvalid   (i_tvalid),
    .o_tready   (o_tready),
    .o_uart_tx  (o_uart_tx),
    .o_busy     (o_busy),
    .o_msg_done (o_msg_done)
  );

  // ---------------- DUT (default parameters) ----------------
  logic [7:0] t2_data  = 8'hFF;
  logic       t2_valid = 1'b0;
  logic       t2_ready;
  logic       t2_tx;
  logic       t2_busy;
  logic       t2_done;

  corescore_uart_tx_stream dut2 (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_tdata    (t2_data),
    .i_tlast    (1'b0),
    .i_tvalid   (t2_valid),
    .o_tready   (t2_ready),
    .o_uart_tx  (t2_tx),
    .o_busy     (t2_busy),
    .o_msg_done (t2_done)
  );

  // ---------------- bookkeeping ----------------
  int n_vec = 0;
  int n_err = 0;
  int n_acc = 0;
  int n_rx  = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- frame-level reference model ----------------
  // A frame is NB bits of DIV4 cycles each; the model tracks only the
  // pending-byte queue and the cycle position inside the current frame.
  logic [8:0]  m_q[$];
  logic [10:0] m_frame  = '1;
  logic        m_last   = 1'b0;
  logic        m_active = 1'b0;
  int          m_t      = 0;
  logic        m_line   = 1'b1;
  logic        m_done   = 1'b0;
  logic        m_tready = 1'b0;
  logic        m_busy   = 1'b0;
  logic        m_pop;
  logic [8:0]  m_e;

  function automatic logic [10:0] make_frame(input logic [7:0] d);
    logic [10:0] f;
    f      = '1;
    f[0]   = 1'b0;
    f[8:1] = d;
`ifdef CORESCORE_UART_TX_PARITY_EN
    f[9]   = ^d;
`endif
    return f;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_q.delete();
      exp_q.delete();
      m_active = 1'b0;
      m_t      = 0;
      m_line   = 1'b1;
      m_done   = 1'b0;
      m_tready = 1'b0;
    end else begin
      m_line = m_active ? m_frame[m_t / DIV4] : 1'b1;
      m_done = m_active && (m_t == FL - 1) && m_last;
      m_pop  = (!m_active || (m_t == FL - 1)) && (m_q.size() > 0);
      if (m_pop) begin
        m_e      = m_q.pop_front();
        m_frame  = make_frame(m_e[7:0]);
        m_last   = m_e[8];
        m_active = 1'b1;
        m_t      = 0;
      end else if (m_active) begin
        if (m_t == FL - 1) m_active = 1'b0;
        else m_t++;
      end
      if (i_tvalid && m_tready) begin
        m_q.push_back({i_tlast, i_tdata});
        exp_q.push_back(i_tdata);
        n_acc++;
      end
      m_tready = (m_q.size() < 16);
    end
    m_busy = m_active || (m_q.size() > 0);
  end

  // ---------------- per-cycle compare ----------------
  logic chk_en = 1'b0;
  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc_uart_tx", o_uart_tx, m_line);
      check("cyc_tready", o_tready, m_tready);
      check("cyc_busy", o_busy, m_busy);
      check("cyc_msg_done", o_msg_done, m_done);
    end
  end

  // ---------------- line decoder / scoreboard ----------------
  logic rx_en = 1'b1;
  initial begin : rx_decoder
    logic       prev;
    logic [7:0] d;
    logic [7:0] e;
    prev = 1'b1;
    d    = '0;
    forever begin
      @(negedge clk);
      if (rx_en && prev && !o_uart_tx && !rst) begin
        repeat (DIV4 / 2) @(negedge clk);
        check("rx_start_mid", o_uart_tx, 1'b0);
        for (int k = 0; k < 8; k++) begin
          repeat (DIV4) @(negedge clk);
          d[k] = o_uart_tx;
        end
`ifdef CORESCORE_UART_TX_PARITY_EN
        repeat (DIV4) @(negedge clk);
        check("rx_parity", o_uart_tx, ^d);
`endif
        repeat (DIV4) @(negedge clk);
        check("rx_stop", o_uart_tx, 1'b1);
        check("rx_expected_pending", exp_q.size() > 0, 1'b1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("rx_byte", d, e);
        end
        n_rx++;
        prev = 1'b1;
      end else begin
        prev = o_uart_tx;
      end
    end
  end

  // ---------------- msg_done / frame timing monitor ----------------
  int   cyc       = 0;
  logic mon_arm   = 1'b0;
  int   first_low = -1;
  int   done_cyc  = -1;
  int   done_cnt  = 0;
  always @(negedge clk) begin
    cyc++;
    if (mon_arm) begin
      if ((first_low < 0) && !o_uart_tx) first_low = cyc;
      if (o_msg_done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  // ---------------- driver tasks (enter and leave just after a negedge) ----------------
  task automatic wait_tready();
    for (int k = 0; k < 400 && !o_tready; k++) @(negedge clk);
    check("tready_wait", o_tready, 1'b1);
  endtask

  task automatic wait_idle(input int budget);
    for (int k = 0; k < budget && (o_busy || m_busy); k++) @(negedge clk);
    check("idle_wait_busy", o_busy, 1'b0);
    repeat (2 * DIV4) @(negedge clk);
  endtask

  // Sends one byte into an idle block and checks the line cycle by cycle
  // against a hand-written frame (bit 0 = start bit, sent first).
  task automatic send_watch(input logic [7:0] d, input logic last,
                            input logic [10:0] frame);
    int c;
    wait_tready();
    i_tdata  = d;
    i_tlast  = last;
    i_tvalid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    i_tvalid = 1'b0;
    i_tlast  = 1'b0;
    for (int j = 1; j <= FL + 1; j++) begin
      @(negedge clk);
      c = j - 1;
      if (c == 0) check("frame_pre_start_idle", o_uart_tx, 1'b1);
      else check("frame_line", o_uart_tx, frame[(c - 1) / DIV4]);
      check("frame_msg_done", o_msg_done, (last && (c == FL)) ? 1'b1 : 1'b0);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int          i;
    int          acc0;
    int          rx0;
    logic        saw_low;
    logic        acc;
    logic [7:0]  b4 [4];
    int          w;

    // reset state
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    check("rst_uart_tx", o_uart_tx, 1'b1);
    check("rst_tready", o_tready, 1'b0);
    check("rst_busy", o_busy, 1'b0);
    check("rst_msg_done", o_msg_done, 1'b0);
    check("rst2_tx", t2_tx, 1'b1);
    check("rst2_busy", t2_busy, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    check("tready_after_release", o_tready, 1'b1);

    // single 0x55 with tlast
`ifdef CORESCORE_UART_TX_PARITY_EN
    send_watch(8'h55, 1'b1, 11'h4AA);
`else
    send_watch(8'h55, 1'b1, 11'h2AA);
`endif
    repeat (4) @(negedge clk);

    // burst of 20 bytes, tlast only on the final one
    mon_arm   = 1'b1;
    first_low = -1;
    done_cnt  = 0;
    i         = 0;
    saw_low   = 1'b0;
    for (int k = 0; k < 3000 && i < 20; k++) begin
      i_tdata  = 8'(i);
      i_tlast  = (i == 19);
      i_tvalid = 1'b1;
      acc      = o_tready;
      if (!o_tready) saw_low = 1'b1;
      @(posedge clk);
      @(negedge clk);
      if (acc) i++;
    end
    i_tvalid = 1'b0;
    i_tlast  = 1'b0;
    check("burst_accepted", i, 20);
    check("burst_tready_dropped", saw_low, 1'b1);
    wait_idle(2000);
    mon_arm = 1'b0;
    check("burst_msg_done_count", done_cnt, 1);
    check("burst_total_cycles", done_cyc - first_low + 1, 20 * FL);

    // reset during data bit 3 of 0xA5
    rx_en = 1'b0;
    wait_tready();
    i_tdata  = 8'hA5;
    i_tlast  = 1'b1;
    i_tvalid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    i_tvalid = 1'b0;
    i_tlast  = 1'b0;
    repeat (18) @(negedge clk);
    check("pre_rst_bit3", o_uart_tx, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_uart_tx", o_uart_tx, 1'b1);
    check("midrst_busy", o_busy, 1'b0);
    check("midrst_tready", o_tready, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    check("midrst_tready_rise", o_tready, 1'b1);
    rx_en = 1'b1;
`ifdef CORESCORE_UART_TX_PARITY_EN
    send_watch(8'h3C, 1'b0, 11'h478);
`else
    send_watch(8'h3C, 1'b0, 11'h278);
`endif
    repeat (4) @(negedge clk);

`ifdef CORESCORE_UART_TX_PARITY_EN
    send_watch(8'h07, 1'b1, 11'h60E);
    repeat (4) @(negedge clk);
    send_watch(8'h03, 1'b0, 11'h406);
    repeat (4) @(negedge clk);
`endif

    // tvalid toggling every other cycle, 4 bytes
    acc0 = n_acc;
    rx0  = n_rx;
    for (int k = 0; k < 4; k++) b4[k] = 8'($urandom_range(0, 255));
    i = 0;
    for (int k = 0; k < 200 && i < 4; k++) begin
      i_tdata  = b4[i];
      i_tvalid = k[0];
      acc      = i_tvalid && o_tready;
      @(posedge clk);
      @(negedge clk);
      if (acc) i++;
    end
    i_tvalid = 1'b0;
    wait_idle(1000);
    check("toggle_accepted", n_acc - acc0, 4);
    check("toggle_received", n_rx - rx0, 4);

    // randomized traffic
    acc0 = n_acc;
    rx0  = n_rx;
    for (int k = 0; k < 30; k++) begin
      i_tvalid = 1'b0;
      repeat ($urandom_range(0, 3)) @(negedge clk);
      i_tdata  = 8'($urandom_range(0, 255));
      i_tlast  = ($urandom_range(0, 3) == 0);
      i_tvalid = 1'b1;
      w = 0;
      do begin
        acc = o_tready;
        @(posedge clk);
        @(negedge clk);
        w++;
      end while (!acc && w < 400);
    end
    i_tvalid = 1'b0;
    i_tlast  = 1'b0;
    wait_idle(3000);
    check("rand_accepted", n_acc - acc0, 30);
    check("rand_received", n_rx - rx0, 30);
    check("scoreboard_drained", exp_q.size(), 0);

    // default parameters: start bit width
    t2_data  = 8'hFF;
    t2_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    t2_valid = 1'b0;
    for (int k = 0; k < 10 && t2_tx; k++) @(negedge clk);
    check("dut2_start_seen", t2_tx, 1'b0);
    w = 0;
    while (!t2_tx && w < 400) begin
      w++;
      @(negedge clk);
    end
    check("dut2_start_width", w, 278);
    check("dut2_busy", t2_busy, 1'b1);
    check("dut2_ready", t2_ready, 1'b1);
    check("dut2_no_done", t2_done, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
